awg_param_ctrl: RTL
===================

Name: awg_param_ctrl

Overview:
- Front-panel control stage that sits directly upstream of the waveform generator.
- Turns four raw active-low push-buttons into the generator's parameter bus: wave select, frequency word, amplitude code and phase offset.
- Provides debounce, edge detection, hold-to-auto-repeat, a field-select/edit state machine and a mute function.
- All outputs are registered and connect directly to the generator's state / state_freq / state_amp / state_phase inputs.

Parameters:
- DEB_CYCLES, 20'd500000: clk cycles a synchronized key level must stay stable before it is accepted (10 ms at 50 MHz).
- HOLD_CYCLES, 25'd25000000: clk cycles a debounced inc/dec key must stay held before auto-repeat starts.
- REPEAT_CYCLES, 25'd5000000: auto-repeat period while held.
- FREQ_MAX, 12'd4095: upper saturation bound for state_freq.

Ports:
- clk  in  1  system clock; same clock as the generator and the DAC.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  4  raw buttons, active low, asynchronous. [0]=field select, [1]=increment, [2]=decrement, [3]=mute toggle.
- state  out  5  wave code to the generator: 0 saw, 1 tri, 2 sqr, 3 sin, 10 muted.
- state_freq  out  12  frequency word.
- state_amp  out  3  amplitude code.
- state_phase  out  8  phase offset.
- field  out  2  field currently being edited, for display: 0 WAVE, 1 FREQ, 2 AMP, 3 PHASE.
- muted  out  1  high while muted.

Behaviour:
- Reset (asynchronous, active-low rst_n) values:
  - state=0, wave register=0, state_freq=1, state_amp=7, state_phase=0, field=WAVE, muted=0.
  - All debounce and repeat counters = 0.
  - Debounced key levels = released.
- Per-key input path:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples.
  - A press pulse is one clk wide, generated on the released->pressed transition of the debounced level.
- Latency: a clean press held from edge T updates the outputs on exactly edge T+DEB_CYCLES+3.
- Auto-repeat:
  - Applies to inc/dec only.
  - While the debounced level stays pressed, an extra press pulse is issued after HOLD_CYCLES, then every REPEAT_CYCLES.
  - The counter clears on release.
  - Select and mute never repeat.
- Field FSM (WAVE->FREQ->AMP->PHASE->WAVE): advances one step per select pulse.
- Edit rules per field (inc / dec):
  - WAVE: 0..3, wraps both ways (3+1=0, 0-1=3).
  - FREQ: 1..FREQ_MAX, saturates at both ends; 0 is never produced.
  - AMP: 0..7, saturates.
  - PHASE: 0..255, wraps modulo 256.
- Mute:
  - Each mute pulse toggles muted.
  - While muted, state=10; the wave register is kept and still editable; unmute restores state to the wave register.
  - Edits to FREQ, AMP and PHASE remain active while muted.
- Simultaneous events in one cycle:
  - inc and dec pulses together: both ignored.
  - Select with inc/dec: the field advances and the inc/dec pulse is dropped.
  - Mute is independent and is applied in the same cycle as any other event.
- Reset mid-operation:
  - Returns all outputs to the reset values immediately, without waiting for clk.
  - A key held through reset release must be debounced again; no pulse is emitted until the key is released and pressed again.
- No combinational path from key_n to any output.

Decomposition:
- Shared package (awg_pkg), constants:
  - WAVE_SAW=0, WAVE_TRI=1, WAVE_SQR=2, WAVE_SIN=3, STATE_MUTE=5'd10.
  - FLD_WAVE..FLD_PHASE.
  - Reset defaults for freq and amp.
- The generator and this block both use awg_pkg for the wave codes.
- One sub-module, key_debounce (synchronizer, stability counter, press pulse, optional repeat enable), instantiated 4×.
- The FSM and the saturating/wrapping arithmetic live in the top.

Test Plan (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
- Reset then idle -> state=0, freq=1, amp=7, phase=0, field=0, muted=0; assert rst_n low mid-edit -> outputs return to defaults with no clk edge.
- key_n[1] bounces low/high every 2 cycles for 12 cycles, then stays low -> exactly one increment: state 0->1, visible DEB_CYCLES+3 edges after it settles low.
- Field=WAVE, three dec presses from 0 -> state 3, 2, 1. Select to FREQ, dec at freq=1 -> stays 1. Select to PHASE, dec at 0 -> 255.
- Field=AMP, inc held 60 cycles after debounce -> amp 7 stays 7. Set amp=2 and hold inc -> first step, then +1 at hold+20, then every 8 cycles until it saturates at 7.
- state=3, mute press -> state=10, muted=1; WAVE inc while muted -> state stays 10; unmute -> state=0.
- inc and dec released to pressed on the same cycle -> no change. Select and inc on the same cycle -> field advances, value unchanged.

Source files
------------

// File: rtl/awg_pkg.sv
// awg_pkg: constants shared by the front-panel control stage and the
// waveform generator.
//   - wave codes carried on the 5-bit state bus, including the mute code
//   - editable-field enumeration shown on the display
//   - reset defaults for the parameter registers
//   - key indices into the key_n bus
//   - wave-select stepping helpers
package awg_pkg;

  localparam logic [4:0] WAVE_SAW   = 5'd0;
  localparam logic [4:0] WAVE_TRI   = 5'd1;
  localparam logic [4:0] WAVE_SQR   = 5'd2;
  localparam logic [4:0] WAVE_SIN   = 5'd3;
  localparam logic [4:0] STATE_MUTE = 5'd10;

  typedef enum logic [1:0] {
    FLD_WAVE  = 2'd0,
    FLD_FREQ  = 2'd1,
    FLD_AMP   = 2'd2,
    FLD_PHASE = 2'd3
  } field_e;

  localparam logic [11:0] FREQ_RST  = 12'd1;
  localparam logic [2:0]  AMP_RST   = 3'd7;
  localparam logic [7:0]  PHASE_RST = 8'd0;

  localparam int KEY_SEL  = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;
  localparam int KEY_MUTE = 3;

  // Wave select steps forward through saw/tri/sqr/sin and wraps.
  function automatic logic [1:0] wave_next(input logic [1:0] w);
    logic [1:0] r;
    case (w)
      WAVE_SAW[1:0]: r = WAVE_TRI[1:0];
      WAVE_TRI[1:0]: r = WAVE_SQR[1:0];
      WAVE_SQR[1:0]: r = WAVE_SIN[1:0];
      default:       r = WAVE_SAW[1:0];
    endcase
    return r;
  endfunction

  // Wave select steps backward and wraps from saw to sin.
  function automatic logic [1:0] wave_prev(input logic [1:0] w);
    logic [1:0] r;
    case (w)
      WAVE_SIN[1:0]: r = WAVE_SQR[1:0];
      WAVE_SQR[1:0]: r = WAVE_TRI[1:0];
      WAVE_TRI[1:0]: r = WAVE_SAW[1:0];
      default:       r = WAVE_SIN[1:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one push-button input path.
//   clk, rst_n : system clock, async active-low reset
//   key_n      : raw asynchronous button, low = pressed
//   press      : registered one-clock pulse per accepted press (plus
//                auto-repeat pulses while held when REPEAT_EN is set)
// After reset the key must first be seen released for DEB_CYCLES samples
// ("armed") before any press can be accepted, so a key held through reset
// never produces a pulse until it is released and pressed again.
module key_debounce #(
  parameter logic [19:0] DEB_CYCLES    = 20'd500000,
  parameter logic [24:0] HOLD_CYCLES   = 25'd25000000,
  parameter logic [24:0] REPEAT_CYCLES = 25'd5000000,
  parameter bit          REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic        sync1_r;
  logic        sync2_r;
  logic        armed_r;
  logic        deb_r;
  logic        deb_d_r;
  logic [19:0] deb_cnt_r;
  logic [24:0] rep_cnt_r;
  logic        rep_phase_r;
  logic        press_r;
  logic        key_pressed_s;
  logic        rise_s;
  logic        fire_s;

  assign key_pressed_s = ~sync2_r;
  assign press         = press_r;

  // Two-flop synchronizer; resets to "pressed" so reset-value samples can
  // never count towards arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter: arms on a stable release, then filters level changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r   <= 1'b0;
      deb_r     <= 1'b0;
      deb_cnt_r <= 20'd0;
    end else if (!armed_r) begin
      deb_r <= 1'b0;
      if (key_pressed_s) begin
        deb_cnt_r <= 20'd0;
      end else if (deb_cnt_r == DEB_CYCLES - 20'd1) begin
        armed_r   <= 1'b1;
        deb_cnt_r <= 20'd0;
      end else begin
        deb_cnt_r <= deb_cnt_r + 20'd1;
      end
    end else if (key_pressed_s == deb_r) begin
      deb_cnt_r <= 20'd0;
    end else if (deb_cnt_r == DEB_CYCLES - 20'd1) begin
      deb_r     <= key_pressed_s;
      deb_cnt_r <= 20'd0;
    end else begin
      deb_cnt_r <= deb_cnt_r + 20'd1;
    end
  end

  // Press edge and auto-repeat fire condition.
  always_comb begin
    rise_s = deb_r & ~deb_d_r;
    if (REPEAT_EN && deb_r && deb_d_r) begin
      if (rep_phase_r) begin
        fire_s = (rep_cnt_r == REPEAT_CYCLES);
      end else begin
        fire_s = (rep_cnt_r == HOLD_CYCLES);
      end
    end else begin
      fire_s = 1'b0;
    end
  end

  // Registered pulse plus a cycles-since-last-pulse counter for auto-repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d_r     <= 1'b0;
      press_r     <= 1'b0;
      rep_cnt_r   <= 25'd0;
      rep_phase_r <= 1'b0;
    end else begin
      deb_d_r <= deb_r;
      press_r <= rise_s | fire_s;
      if (!REPEAT_EN || !deb_r) begin
        rep_cnt_r   <= 25'd0;
        rep_phase_r <= 1'b0;
      end else if (rise_s || fire_s) begin
        rep_cnt_r   <= 25'd1;
        rep_phase_r <= rep_phase_r | fire_s;
      end else begin
        rep_cnt_r <= rep_cnt_r + 25'd1;
      end
    end
  end

endmodule

// File: rtl/awg_param_ctrl.sv
// awg_param_ctrl: front-panel control stage for the waveform generator.
//   clk, rst_n  : system clock, async active-low reset
//   key_n[3:0]  : raw active-low buttons: 0 select, 1 inc, 2 dec, 3 mute
//   state       : wave code (0..3) or STATE_MUTE while muted
//   state_freq  : frequency word, saturating in 1..FREQ_MAX
//   state_amp   : amplitude code, saturating in 0..7
//   state_phase : phase offset, wrapping modulo 256
//   field       : field currently being edited
//   muted       : high while muted
// All outputs are registers; key_n only reaches them through the debouncers.
module awg_param_ctrl
  import awg_pkg::*;
#(
  parameter logic [19:0] DEB_CYCLES    = 20'd500000,
  parameter logic [24:0] HOLD_CYCLES   = 25'd25000000,
  parameter logic [24:0] REPEAT_CYCLES = 25'd5000000,
  parameter logic [11:0] FREQ_MAX      = 12'd4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_n,
  output logic [4:0]  state,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  field,
  output logic        muted
);

  logic [3:0]  press_s;
  field_e      field_r;
  field_e      field_nxt_s;
  logic [1:0]  wave_r;
  logic [1:0]  wave_nxt_s;
  logic [11:0] freq_r;
  logic [11:0] freq_nxt_s;
  logic [2:0]  amp_r;
  logic [2:0]  amp_nxt_s;
  logic [7:0]  phase_r;
  logic [7:0]  phase_nxt_s;
  logic        muted_r;
  logic        muted_nxt_s;
  logic [4:0]  state_r;
  logic [4:0]  state_nxt_s;
  logic        inc_s;
  logic        dec_s;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    key_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .REPEAT_EN     (gi == KEY_INC || gi == KEY_DEC)
    ) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_n[gi]),
      .press (press_s[gi])
    );
  end

  // Field state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_r <= FLD_WAVE;
    end else begin
      field_r <= field_nxt_s;
    end
  end

  // Next field, parameter edits and mute; select or a clashing inc/dec
  // cancels the edit, mute is applied independently.
  always_comb begin
    field_nxt_s = field_r;
    wave_nxt_s  = wave_r;
    freq_nxt_s  = freq_r;
    amp_nxt_s   = amp_r;
    phase_nxt_s = phase_r;
    muted_nxt_s = muted_r;
    inc_s = press_s[KEY_INC] & ~press_s[KEY_DEC] & ~press_s[KEY_SEL];
    dec_s = press_s[KEY_DEC] & ~press_s[KEY_INC] & ~press_s[KEY_SEL];

    if (press_s[KEY_SEL]) begin
      case (field_r)
        FLD_WAVE:  field_nxt_s = FLD_FREQ;
        FLD_FREQ:  field_nxt_s = FLD_AMP;
        FLD_AMP:   field_nxt_s = FLD_PHASE;
        FLD_PHASE: field_nxt_s = FLD_WAVE;
        default:   field_nxt_s = FLD_WAVE;
      endcase
    end else begin
      field_nxt_s = field_r;
    end

    if (press_s[KEY_MUTE]) begin
      muted_nxt_s = ~muted_r;
    end else begin
      muted_nxt_s = muted_r;
    end

    if (inc_s) begin
      case (field_r)
        FLD_WAVE: wave_nxt_s = wave_next(wave_r);
        FLD_FREQ: begin
          if (freq_r >= FREQ_MAX) begin
            freq_nxt_s = FREQ_MAX;
          end else begin
            freq_nxt_s = freq_r + 12'd1;
          end
        end
        FLD_AMP: begin
          if (amp_r == 3'd7) begin
            amp_nxt_s = 3'd7;
          end else begin
            amp_nxt_s = amp_r + 3'd1;
          end
        end
        FLD_PHASE: phase_nxt_s = phase_r + 8'd1;
        default:   wave_nxt_s  = wave_r;
      endcase
    end else if (dec_s) begin
      case (field_r)
        FLD_WAVE: wave_nxt_s = wave_prev(wave_r);
        FLD_FREQ: begin
          if (freq_r <= 12'd1) begin
            freq_nxt_s = 12'd1;
          end else begin
            freq_nxt_s = freq_r - 12'd1;
          end
        end
        FLD_AMP: begin
          if (amp_r == 3'd0) begin
            amp_nxt_s = 3'd0;
          end else begin
            amp_nxt_s = amp_r - 3'd1;
          end
        end
        FLD_PHASE: phase_nxt_s = phase_r - 8'd1;
        default:   wave_nxt_s  = wave_r;
      endcase
    end else begin
      wave_nxt_s = wave_r;
    end

    // The wave register keeps being edited while muted; only the bus is forced.
    if (muted_nxt_s) begin
      state_nxt_s = STATE_MUTE;
    end else begin
      state_nxt_s = {3'b000, wave_nxt_s};
    end
  end

  // Parameter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_r  <= WAVE_SAW[1:0];
      freq_r  <= FREQ_RST;
      amp_r   <= AMP_RST;
      phase_r <= PHASE_RST;
      muted_r <= 1'b0;
      state_r <= WAVE_SAW;
    end else begin
      wave_r  <= wave_nxt_s;
      freq_r  <= freq_nxt_s;
      amp_r   <= amp_nxt_s;
      phase_r <= phase_nxt_s;
      muted_r <= muted_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign state       = state_r;
  assign state_freq  = freq_r;
  assign state_amp   = amp_r;
  assign state_phase = phase_r;
  assign field       = field_r;
  assign muted       = muted_r;

endmodule
